// File: rtl/boot_pkg.sv
// -----------------------------------------------------------------------------
// boot_pkg
// Shared definitions for the boot responder: FSM state encoding, message
// identifiers, message lengths and the ASCII characters used in the banners.
// -----------------------------------------------------------------------------
package boot_pkg;

    // Transmit sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_START     = 3'd2,
        ST_WAIT_BUSY = 3'd3,
        ST_WAIT_IDLE = 3'd4
    } state_t;

    // Message identifiers.
    typedef enum logic {
        MSG_RDY  = 1'b0,
        MSG_DONE = 1'b1
    } msg_t;

    // Message lengths in bytes, terminator included.
    localparam int RDY_LEN  = 4;
    localparam int DONE_LEN = 14;

    // Index of the final byte of each message.
    localparam logic [3:0] RDY_LAST  = 4'(RDY_LEN - 1);
    localparam logic [3:0] DONE_LAST = 4'(DONE_LEN - 1);

    // Message characters.
    localparam logic [7:0] ASCII_R  = 8'h52;
    localparam logic [7:0] ASCII_D  = 8'h44;
    localparam logic [7:0] ASCII_Y  = 8'h59;
    localparam logic [7:0] ASCII_O  = 8'h4F;
    localparam logic [7:0] ASCII_N  = 8'h4E;
    localparam logic [7:0] ASCII_E  = 8'h45;
    localparam logic [7:0] ASCII_SP = 8'h20;

    // Bases of the two hex digit ranges.
    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;

endpackage

// File: rtl/hex_ascii.sv
// -----------------------------------------------------------------------------
// hex_ascii
// Combinational conversion of one 4-bit nibble to its uppercase ASCII hex
// character ('0'-'9', 'A'-'F').
//
// Ports:
//   nibble_i  in   4  value to convert
//   ascii_o   out  8  ASCII character
// -----------------------------------------------------------------------------
module hex_ascii
    import boot_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [7:0] ascii_o
);

    assign ascii_o = (nibble_i < 4'd10) ? (ASCII_ZERO + {4'd0, nibble_i})
                                        : (ASCII_A + {4'd0, nibble_i - 4'd10});

endmodule

// File: rtl/boot_responder.sv
// -----------------------------------------------------------------------------
// boot_responder
// UART-transmit side of the host boot protocol. Sends "RDY" when programming
// starts, counts received program bytes, and on the programming timeout sends
// "DONE " followed by the byte count as 8 uppercase hex digits. Every message
// ends with EOL_BYTE. Bytes are handed to the UART one at a time, each waiting
// for the transmitter to go busy and then idle again.
//
// Parameters:
//   SEND_RDY  1 = send the RDY banner on programming start, 0 = suppress it
//   EOL_BYTE  line terminator appended to every message
//
// Ports:
//   clk_i         in   1   system clock
//   reset_i       in   1   asynchronous active-low reset
//   prog_start_i  in   1   pulse: programming mode entered
//   prog_done_i   in   1   pulse: programming idle timeout expired
//   rx_irq_i      in   1   pulse per UART byte received
//   tx_busy_i     in   1   UART transmitter busy
//   tx_start_o    out  1   one-cycle request to send tx_byte_o
//   tx_byte_o     out  8   byte to transmit
//   byte_count_o  out  32  bytes received since the last prog_start_i
//   active_o      out  1   high while a message is being transmitted
// -----------------------------------------------------------------------------
module boot_responder #(
    parameter bit         SEND_RDY = 1'b1,
    parameter logic [7:0] EOL_BYTE = 8'h0A
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        prog_start_i,
    input  logic        prog_done_i,
    input  logic        rx_irq_i,
    input  logic        tx_busy_i,
    output logic        tx_start_o,
    output logic [7:0]  tx_byte_o,
    output logic [31:0] byte_count_o,
    output logic        active_o
);
    import boot_pkg::*;

    state_t      r_state;
    msg_t        r_msg;
    logic [3:0]  r_idx;
    logic        r_tx_start;
    logic [7:0]  r_tx_byte;
    logic        r_active;
    logic        r_pend_rdy;
    logic        r_pend_done;
    logic [31:0] r_count;
    logic [31:0] r_shadow;
    logic [31:0] r_snap;

    logic [31:0] w_count_next;
    logic [2:0]  w_hex_pos;
    logic [3:0]  w_nibble;
    logic [7:0]  w_hex_ascii;
    logic [7:0]  w_msg_byte;
    logic [3:0]  w_last_idx;

    // Clear beats increment when both arrive together; a byte arriving with
    // prog_done_i is part of the reported count.
    assign w_count_next = prog_start_i ? '0 : (r_count + {31'd0, rx_irq_i});

    // Byte counter and the latest timeout snapshot. The shadow always tracks
    // the most recent prog_done_i; it is copied into r_snap only when a DONE
    // message is selected, so a message in flight reports a frozen value.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_count  <= '0;
            r_shadow <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every
            // always_ff reads the pre-edge value regardless of block order.
            r_count <= w_count_next;
            if (prog_done_i) begin
                r_shadow <= w_count_next;
            end
        end
    end

    // Hex digits occupy DONE indices 5..12, most significant nibble first,
    // so index 5 maps to nibble 7 and index 12 to nibble 0.
    assign w_hex_pos = 3'(DONE_LAST - 4'd1 - r_idx);
    assign w_nibble  = r_snap[{w_hex_pos, 2'b00} +: 4];

    hex_ascii u_hex_ascii (
        .nibble_i (w_nibble),
        .ascii_o  (w_hex_ascii)
    );

    // Message ROM.
    always_comb begin
        // NOTE: default assignment first so no path through the block leaves
        // w_msg_byte unassigned and infers a latch.
        w_msg_byte = EOL_BYTE;
        if (r_msg == MSG_RDY) begin
            case (r_idx)
                4'd0:    w_msg_byte = ASCII_R;
                4'd1:    w_msg_byte = ASCII_D;
                4'd2:    w_msg_byte = ASCII_Y;
                default: w_msg_byte = EOL_BYTE;
            endcase
        end else begin
            case (r_idx)
                4'd0:      w_msg_byte = ASCII_D;
                4'd1:      w_msg_byte = ASCII_O;
                4'd2:      w_msg_byte = ASCII_N;
                4'd3:      w_msg_byte = ASCII_E;
                4'd4:      w_msg_byte = ASCII_SP;
                DONE_LAST: w_msg_byte = EOL_BYTE;
                default:   w_msg_byte = w_hex_ascii;
            endcase
        end
    end

    assign w_last_idx = (r_msg == MSG_RDY) ? RDY_LAST : DONE_LAST;

    // Transmit sequencer with registered outputs.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state     <= ST_IDLE;
            r_msg       <= MSG_RDY;
            r_idx       <= '0;
            r_tx_start  <= 1'b0;
            r_tx_byte   <= '0;
            r_active    <= 1'b0;
            r_pend_rdy  <= 1'b0;
            r_pend_done <= 1'b0;
            r_snap      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // RDY is served before DONE when both are pending.
                    if (r_pend_rdy || r_pend_done) begin
                        r_idx    <= '0;
                        r_active <= 1'b1;
                        r_state  <= ST_LOAD;
                        if (r_pend_rdy) begin
                            r_msg      <= MSG_RDY;
                            r_pend_rdy <= 1'b0;
                        end else begin
                            r_msg       <= MSG_DONE;
                            r_pend_done <= 1'b0;
                            r_snap      <= r_shadow;
                        end
                    end
                end
                ST_LOAD: begin
                    r_tx_byte <= w_msg_byte;
                    if (!tx_busy_i) begin
                        r_tx_start <= 1'b1;
                        r_state    <= ST_START;
                    end
                end
                ST_START: begin
                    r_tx_start <= 1'b0;
                    r_state    <= ST_WAIT_BUSY;
                end
                ST_WAIT_BUSY: begin
                    if (tx_busy_i) begin
                        r_state <= ST_WAIT_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (!tx_busy_i) begin
                        if (r_idx == w_last_idx) begin
                            r_active <= 1'b0;
                            r_state  <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + 4'd1;
                            r_state <= ST_LOAD;
                        end
                    end
                end
                default: begin
                    r_tx_start <= 1'b0;
                    r_active   <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase

            // Placed after the FSM so a new event wins over the clear done
            // when the previous request of the same kind is being selected.
            if (prog_start_i && SEND_RDY) begin
                r_pend_rdy <= 1'b1;
            end
            if (prog_done_i) begin
                r_pend_done <= 1'b1;
            end
        end
    end

    assign tx_start_o   = r_tx_start;
    assign tx_byte_o    = r_tx_byte;
    assign byte_count_o = r_count;
    assign active_o     = r_active;

endmodule

// File: tb/tb_boot_responder.sv
// -----------------------------------------------------------------------------
// tb_boot_responder
// Two instances share the host-side inputs: u_dut with the default parameters
// and u_dut_nr with the banner suppressed and a CR terminator. Each has its own
// UART model (busy from the cycle after tx_start_o, for TX_LEN cycles) and a
// monitor collecting transmitted bytes. Expected byte streams are built from
// the message definitions and a plain running count of received bytes.
// -----------------------------------------------------------------------------
module tb_boot_responder;

    localparam int         TX_LEN   = 10;
    localparam int         BYTE_GAP = TX_LEN + 2;  // start-to-start inside a message
    localparam int         MSG_GAP  = TX_LEN + 3;  // one extra IDLE cycle between messages
    localparam logic [7:0] EOL_MAIN = 8'h0A;
    localparam logic [7:0] EOL_NR   = 8'h0D;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        prog_start_i;
    logic        prog_done_i;
    logic        rx_irq_i;
    logic        tx_busy_i;
    logic        tx_busy_nr;

    logic        tx_start_o,   tx_start_nr;
    logic [7:0]  tx_byte_o,    tx_byte_nr;
    logic [31:0] byte_count_o, byte_count_nr;
    logic        active_o,     active_nr;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] q_got[$];
    logic [7:0] q_exp[$];
    logic [7:0] q_got_nr[$];
    logic [7:0] q_exp_nr[$];
    int         q_cyc[$];

    logic [31:0] m_count;
    logic [31:0] m_snap;

    boot_responder #(.SEND_RDY(1'b1), .EOL_BYTE(EOL_MAIN)) u_dut (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .prog_start_i (prog_start_i),
        .prog_done_i  (prog_done_i),
        .rx_irq_i     (rx_irq_i),
        .tx_busy_i    (tx_busy_i),
        .tx_start_o   (tx_start_o),
        .tx_byte_o    (tx_byte_o),
        .byte_count_o (byte_count_o),
        .active_o     (active_o)
    );

    boot_responder #(.SEND_RDY(1'b0), .EOL_BYTE(EOL_NR)) u_dut_nr (
        .clk_i        (clk_i),
        .reset_i      (reset_i),
        .prog_start_i (prog_start_i),
        .prog_done_i  (prog_done_i),
        .rx_irq_i     (rx_irq_i),
        .tx_busy_i    (tx_busy_nr),
        .tx_start_o   (tx_start_nr),
        .tx_byte_o    (tx_byte_nr),
        .byte_count_o (byte_count_nr),
        .active_o     (active_nr)
    );

    always #5 clk_i = ~clk_i;

    // UART models.
    initial begin
        tx_busy_i = 1'b0;
        forever begin
            @(negedge clk_i);
            if (tx_start_o) begin
                tx_busy_i = 1'b1;
                repeat (TX_LEN) @(negedge clk_i);
                tx_busy_i = 1'b0;
            end
        end
    end

    initial begin
        tx_busy_nr = 1'b0;
        forever begin
            @(negedge clk_i);
            if (tx_start_nr) begin
                tx_busy_nr = 1'b1;
                repeat (TX_LEN) @(negedge clk_i);
                tx_busy_nr = 1'b0;
            end
        end
    end

    // Monitors: one entry per cycle in which tx_start is high.
    initial begin
        forever begin
            @(negedge clk_i);
            cyc++;
            if (tx_start_o) begin
                q_got.push_back(tx_byte_o);
                q_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            if (tx_start_nr) q_got_nr.push_back(tx_byte_nr);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Expected message builders.
    task automatic exp_rdy();
        string s = "RDY";
        for (int i = 0; i < 3; i++) q_exp.push_back(s[i]);
        q_exp.push_back(EOL_MAIN);
    endtask

    task automatic exp_done(input logic [31:0] v, input bit nr);
        string      s = "DONE ";
        logic [7:0] b[$];
        int         d;
        for (int i = 0; i < 5; i++) b.push_back(s[i]);
        for (int k = 7; k >= 0; k--) begin
            d = int'((v >> (4 * k)) % 32'd16);
            b.push_back((d < 10) ? 8'(8'h30 + d) : 8'(8'h41 + d - 10));
        end
        b.push_back(nr ? EOL_NR : EOL_MAIN);
        foreach (b[i]) begin
            if (nr) q_exp_nr.push_back(b[i]);
            else    q_exp.push_back(b[i]);
        end
    endtask

    task automatic compare(input string tag);
        check({tag, "_nbytes"}, 32'(q_got.size()), 32'(q_exp.size()));
        foreach (q_exp[i])
            check($sformatf("%s_byte%0d", tag, i),
                  (i < q_got.size()) ? 32'(q_got[i]) : 32'hFFFF_FFFF, 32'(q_exp[i]));
        check({tag, "_nr_nbytes"}, 32'(q_got_nr.size()), 32'(q_exp_nr.size()));
        foreach (q_exp_nr[i])
            check($sformatf("%s_nr_byte%0d", tag, i),
                  (i < q_got_nr.size()) ? 32'(q_got_nr[i]) : 32'hFFFF_FFFF, 32'(q_exp_nr[i]));
        q_got.delete();
        q_exp.delete();
        q_got_nr.delete();
        q_exp_nr.delete();
        q_cyc.delete();
    endtask

    // One stimulus cycle, starting at a falling edge; also advances the model.
    task automatic cycle(input bit s, input bit d, input bit r);
        prog_start_i = s;
        prog_done_i  = d;
        rx_irq_i     = r;
        if (s)      m_count = '0;
        else if (r) m_count = m_count + 32'd1;
        if (d)      m_snap = m_count;
        @(negedge clk_i);
        prog_start_i = 1'b0;
        prog_done_i  = 1'b0;
        rx_irq_i     = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        for (int i = 0; i < 3000 && quiet < 6; i++) begin
            @(negedge clk_i);
            if (!active_o && !active_nr && !tx_busy_i && !tx_busy_nr) quiet++;
            else quiet = 0;
        end
        check({tag, "_idle"}, 32'(quiet >= 6), 32'd1);
    endtask

    // Returns 1 ns after the falling edge on which the n-th main byte starts.
    task automatic wait_bytes(input string tag, input int n);
        int i = 0;
        while (q_got.size() < n && i < 2000) begin
            @(negedge clk_i);
            #1;
            i++;
        end
        check({tag, "_reached"}, 32'(q_got.size() >= n), 32'd1);
    endtask

    task automatic force_count(input logic [31:0] v);
        force u_dut.r_count    = v;
        force u_dut_nr.r_count = v;
        @(negedge clk_i);
        release u_dut.r_count;
        release u_dut_nr.r_count;
        m_count = v;
    endtask

    initial begin
        logic [31:0] v1, v2;
        int          k;

        #800_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v1;
        logic [31:0] v2;
        int          k;

        reset_i      = 1'b0;
        prog_start_i = 1'b0;
        prog_done_i  = 1'b0;
        rx_irq_i     = 1'b0;
        m_count      = '0;
        m_snap       = '0;
        repeat (3) @(negedge clk_i);
        check("rst_tx_start", 32'(tx_start_o), 32'd0);
        check("rst_tx_byte",  32'(tx_byte_o),  32'd0);
        check("rst_count",    byte_count_o,    32'd0);
        check("rst_active",   32'(active_o),   32'd0);
        check("rst_nr_active", 32'(active_nr), 32'd0);
        reset_i = 1'b1;
        @(negedge clk_i);

        // RDY banner and start latency.
        cycle(1'b1, 1'b0, 1'b0);
        check("lat_c1", 32'(tx_start_o), 32'd0);
        @(negedge clk_i);
        check("lat_c2", 32'(tx_start_o), 32'd0);
        @(negedge clk_i);
        check("lat_c3", 32'(tx_start_o), 32'd1);
        check("lat_byte", 32'(tx_byte_o), 32'h52);
        check("active_during", 32'(active_o), 32'd1);
        wait_idle("rdy");
        check("active_after", 32'(active_o), 32'd0);
        check("rdy_byte_gap", (q_cyc.size() > 1) ? 32'(q_cyc[1] - q_cyc[0]) : 32'hFFFF_FFFF,
              32'(BYTE_GAP));
        exp_rdy();
        compare("rdy");

        // 300 bytes then timeout.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (300) cycle(1'b0, 1'b0, 1'b1);
        check("count300", byte_count_o, 32'd300);
        check("count300_nr", byte_count_nr, m_count);
        cycle(1'b0, 1'b1, 1'b0);
        wait_idle("done300");
        exp_rdy();
        exp_done(m_snap, 1'b0);
        exp_done(m_snap, 1'b1);
        compare("done300");

        // Same-cycle events.
        cycle(1'b1, 1'b0, 1'b1);
        check("start_rx_clear", byte_count_o, 32'd0);
        repeat (15) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1);
        wait_idle("done_rx");
        exp_rdy();
        exp_done(32'h10, 1'b0);
        exp_done(32'h10, 1'b1);
        compare("done_rx");

        // Two timeouts while RDY is in flight on the main instance.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (5) @(negedge clk_i);
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        v1 = m_snap;
        repeat (4) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        v2 = m_snap;
        wait_idle("queued");
        check("msg_gap", (q_cyc.size() > 4) ? 32'(q_cyc[4] - q_cyc[3]) : 32'hFFFF_FFFF,
              32'(MSG_GAP));
        exp_rdy();
        exp_done(v2, 1'b0);
        exp_done(v1, 1'b1);
        exp_done(v2, 1'b1);
        compare("queued");

        // Timeout during a DONE message: the first keeps its value.
        cycle(1'b1, 1'b0, 1'b0);
        wait_idle("dd_rdy");
        exp_rdy();
        repeat (5) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        v1 = m_snap;
        wait_bytes("dd", 7);
        repeat (2) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        v2 = m_snap;
        wait_idle("dd");
        exp_done(v1, 1'b0);
        exp_done(v2, 1'b0);
        exp_done(v1, 1'b1);
        exp_done(v2, 1'b1);
        compare("dd");

        // Counter wrap.
        force_count(32'hFFFF_FFFE);
        check("forced_count", byte_count_o, 32'hFFFF_FFFE);
        repeat (3) cycle(1'b0, 1'b0, 1'b1);
        check("wrap_count", byte_count_o, m_count);
        cycle(1'b0, 1'b1, 1'b0);
        wait_idle("wrap");
        exp_done(m_snap, 1'b0);
        exp_done(m_snap, 1'b1);
        compare("wrap");

        // A-F digits.
        force_count(32'hDEAD_BEEF);
        cycle(1'b0, 1'b1, 1'b0);
        wait_idle("deadbeef");
        exp_done(32'hDEAD_BEEF, 1'b0);
        exp_done(32'hDEAD_BEEF, 1'b1);
        compare("deadbeef");

        // Randomised sessions.
        for (int it = 0; it < 6; it++) begin
            cycle(1'b1, 1'b0, 1'($urandom_range(0, 1)));
            k = int'($urandom_range(0, 60));
            for (int j = 0; j < k; j++) begin
                cycle(1'b0, 1'b0, 1'b1);
                repeat ($urandom_range(0, 3)) @(negedge clk_i);
            end
            cycle(1'b0, 1'b1, 1'($urandom_range(0, 1)));
            check($sformatf("rand%0d_count", it), byte_count_o, m_count);
            wait_idle($sformatf("rand%0d", it));
            exp_rdy();
            exp_done(m_snap, 1'b0);
            exp_done(m_snap, 1'b1);
            compare($sformatf("rand%0d", it));
        end

        // Reset in the middle of the sixth DONE byte.
        cycle(1'b1, 1'b0, 1'b0);
        repeat (20) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        wait_bytes("midrst", 10);
        check("midrst_pre_start", 32'(tx_start_o), 32'd1);
        reset_i = 1'b0;
        #1;
        check("midrst_tx_start", 32'(tx_start_o), 32'd0);
        check("midrst_tx_byte",  32'(tx_byte_o),  32'd0);
        check("midrst_count",    byte_count_o,    32'd0);
        check("midrst_active",   32'(active_o),   32'd0);
        check("midrst_nr_active", 32'(active_nr), 32'd0);
        @(negedge clk_i);
        reset_i = 1'b1;
        m_count = '0;
        q_got.delete();
        q_got_nr.delete();
        q_cyc.delete();
        repeat (100) @(negedge clk_i);
        check("midrst_no_restart",    32'(q_got.size()),    32'd0);
        check("midrst_nr_no_restart", 32'(q_got_nr.size()), 32'd0);
        check("midrst_count_after",   byte_count_o,         m_count);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
